// File: rtl/branch_predictor_bht.sv
// Direct-mapped branch history/target table for fetch-side next-PC prediction.
// Trained by resolved outcomes from EX; issues a registered redirect/flush on misprediction.
module branch_predictor_bht #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned TAG_W = 26,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      f_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_target,
   input  logic             u_valid,
   input  logic [31:0]      u_pc,
   input  logic             u_is_branch,
   input  logic             u_taken,
   input  logic [31:0]      u_target,
   input  logic             u_pred_taken,
   input  logic [31:0]      u_pred_target,
   output logic             redirect_valid,
   output logic [31:0]      redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int unsigned DEPTH = 2 ** IDX_W;

   logic             valid_q [DEPTH];
   logic [TAG_W-1:0] tag_q   [DEPTH];
   logic [29:0]      tgt_q   [DEPTH];
   logic [1:0]       ctr_q   [DEPTH];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [31:0]      actual_next;
   logic [31:0]      predicted_next;
   logic             mispredict;

   // Lookup reads only registered state, so a same-cycle update is not visible.
   always_comb begin
      f_idx       = f_pc[IDX_W+1:2];
      f_tag       = f_pc[IDX_W+1+TAG_W:IDX_W+2];
      f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      pred_taken  = f_hit && ctr_q[f_idx][1];
      pred_target = pred_taken ? {tgt_q[f_idx], 2'b00} : f_pc + 32'd4;
   end

   always_comb begin
      u_idx          = u_pc[IDX_W+1:2];
      u_tag          = u_pc[IDX_W+1+TAG_W:IDX_W+2];
      u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      actual_next    = (u_is_branch && u_taken) ? u_target : u_pc + 32'd4;
      predicted_next = u_pred_taken ? u_pred_target : u_pc + 32'd4;
      mispredict     = (actual_next != predicted_next);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= 2'b01;
         end
      end else if (u_valid) begin
         if (u_is_branch) begin
            if (u_hit) begin
               if (u_taken) begin
                  if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'b01;
                  tgt_q[u_idx] <= u_target[31:2];
               end else if (ctr_q[u_idx] != 2'b00) begin
                  ctr_q[u_idx] <= ctr_q[u_idx] - 2'b01;
               end
            end else if (u_taken) begin
               valid_q[u_idx] <= 1'b1;
               tag_q[u_idx]   <= u_tag;
               tgt_q[u_idx]   <= u_target[31:2];
               ctr_q[u_idx]   <= 2'b10;
            end
         end else if (u_hit) begin
            // A non-branch aliasing onto a live entry would keep mispredicting.
            valid_q[u_idx] <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush          <= 1'b0;
      end else begin
         redirect_valid <= u_valid && mispredict;
         flush          <= u_valid && mispredict;
         if (u_valid && mispredict) redirect_pc <= actual_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else if (u_valid) begin
         if (u_is_branch && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
         if (mispredict && (mispredict_cnt != '1)) mispredict_cnt <= mispredict_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht; a second narrow-counter instance exercises saturation.
module tb_branch_predictor_bht;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] f_pc;
   logic        u_valid;
   logic [31:0] u_pc;
   logic        u_is_branch;
   logic        u_taken;
   logic [31:0] u_target;
   logic        u_pred_taken;
   logic [31:0] u_pred_target;

   logic        pred_taken, redirect_valid, flush;
   logic [31:0] pred_target, redirect_pc;
   logic [15:0] branch_cnt, mispredict_cnt;

   logic        s_pred_taken, s_redirect_valid, s_flush;
   logic [31:0] s_pred_target, s_redirect_pc;
   logic [2:0]  s_branch_cnt, s_mispredict_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   branch_predictor_bht dut (
      .clk(clk), .reset(reset), .f_pc(f_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .u_valid(u_valid), .u_pc(u_pc), .u_is_branch(u_is_branch), .u_taken(u_taken),
      .u_target(u_target), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
      .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
   );

   branch_predictor_bht #(.IDX_W(4), .TAG_W(26), .CNT_W(3)) u_sat (
      .clk(clk), .reset(reset), .f_pc(f_pc),
      .pred_taken(s_pred_taken), .pred_target(s_pred_target),
      .u_valid(u_valid), .u_pc(u_pc), .u_is_branch(u_is_branch), .u_taken(u_taken),
      .u_target(u_target), .u_pred_taken(u_pred_taken), .u_pred_target(u_pred_target),
      .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
      .branch_cnt(s_branch_cnt), .mispredict_cnt(s_mispredict_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic tk,
                      input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
      u_valid       = 1'b1;
      u_pc          = pc;
      u_is_branch   = br;
      u_taken       = tk;
      u_target      = tgt;
      u_pred_taken  = pt;
      u_pred_target = ptgt;
   endtask

   task automatic look(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt,
                       input string tag);
      f_pc = pc;
      #1;
      check({tag, "_taken"}, 32'(pred_taken), 32'(exp_tk));
      check({tag, "_target"}, pred_target, exp_tgt);
   endtask

   initial begin
      reset = 1'b0; f_pc = 32'h100; u_valid = 1'b0; u_pc = '0; u_is_branch = 1'b0;
      u_taken = 1'b0; u_target = '0; u_pred_taken = 1'b0; u_pred_target = '0;

      // 1: reset state
      #2;
      look(32'h100, 1'b0, 32'h104, "rst_lookup");
      check("rst_redirect_async", 32'(redirect_valid), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      step();
      check("rst_redirect", 32'(redirect_valid), 32'd0);
      check("rst_flush", 32'(flush), 32'd0);
      check("rst_branch_cnt", 32'(branch_cnt), 32'd0);
      check("rst_mis_cnt", 32'(mispredict_cnt), 32'd0);

      // 2: allocate on taken miss; lookup in the update cycle sees the old entry
      upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      look(32'h100, 1'b0, 32'h104, "nobypass");
      step();
      u_valid = 1'b0;
      check("alloc_redirect", 32'(redirect_valid), 32'd1);
      check("alloc_redirect_pc", redirect_pc, 32'h200);
      check("alloc_flush", 32'(flush), 32'd1);
      check("alloc_mis_cnt", 32'(mispredict_cnt), 32'd1);
      check("alloc_branch_cnt", 32'(branch_cnt), 32'd1);
      look(32'h100, 1'b1, 32'h200, "alloc_lookup");

      // 3: two back-to-back not-taken updates, counter 10->01->00
      upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b1, 32'h200);
      step();
      check("nt1_redirect", 32'(redirect_valid), 32'd1);
      check("nt1_redirect_pc", redirect_pc, 32'h104);
      step();
      u_valid = 1'b0;
      check("nt2_redirect", 32'(redirect_valid), 32'd1);
      check("nt2_redirect_pc", redirect_pc, 32'h104);
      check("nt2_mis_cnt", 32'(mispredict_cnt), 32'd3);
      check("nt2_branch_cnt", 32'(branch_cnt), 32'd3);
      step();
      check("idle_redirect", 32'(redirect_valid), 32'd0);
      check("idle_flush", 32'(flush), 32'd0);
      check("idle_redirect_hold", redirect_pc, 32'h104);
      look(32'h100, 1'b0, 32'h104, "nt_lookup");

      // counter floor: a third not-taken keeps 00, so one taken only reaches 01
      upd(32'h100, 1'b1, 1'b0, 32'h200, 1'b0, 32'h0);
      step();
      check("nt3_redirect", 32'(redirect_valid), 32'd0);
      upd(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      step();
      u_valid = 1'b0;
      check("tk_redirect_pc", redirect_pc, 32'h200);
      check("tk_mis_cnt", 32'(mispredict_cnt), 32'd4);
      check("tk_branch_cnt", 32'(branch_cnt), 32'd5);
      look(32'h100, 1'b0, 32'h104, "floor_lookup");

      // 4: aliasing PC at same index replaces the entry
      upd(32'h140, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
      step();
      u_valid = 1'b0;
      check("repl_redirect_pc", redirect_pc, 32'h300);
      look(32'h100, 1'b0, 32'h104, "repl_old");
      look(32'h140, 1'b1, 32'h300, "repl_new");

      // 5: non-branch hit invalidates; wrap-around PC
      upd(32'h140, 1'b0, 1'b0, 32'h0, 1'b1, 32'h300);
      step();
      check("nb_redirect", 32'(redirect_valid), 32'd1);
      check("nb_redirect_pc", redirect_pc, 32'h144);
      check("nb_branch_cnt", 32'(branch_cnt), 32'd6);
      check("nb_mis_cnt", 32'(mispredict_cnt), 32'd6);
      upd(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      u_valid = 1'b0;
      check("wrap_redirect", 32'(redirect_valid), 32'd0);
      check("wrap_redirect_hold", redirect_pc, 32'h144);
      check("wrap_branch_cnt", 32'(branch_cnt), 32'd7);
      look(32'h140, 1'b0, 32'h144, "nb_lookup");
      look(32'hFFFF_FFFC, 1'b0, 32'h0, "wrap_lookup");

      // saturation: ten mispredicting branches, narrow counters stop at 7
      upd(32'h180, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0);
      repeat (10) step();
      u_valid = 1'b0;
      check("sat_mis_cnt_wide", 32'(mispredict_cnt), 32'd16);
      check("sat_branch_cnt_wide", 32'(branch_cnt), 32'd17);
      check("sat_mis_cnt_narrow", 32'(s_mispredict_cnt), 32'd7);
      check("sat_branch_cnt_narrow", 32'(s_branch_cnt), 32'd7);
      look(32'h180, 1'b1, 32'h400, "sat_lookup");

      // 6: asynchronous reset while a redirect is pending
      upd(32'h1C0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0);
      step();
      u_valid = 1'b0;
      check("pre_rst_redirect", 32'(redirect_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("arst_redirect", 32'(redirect_valid), 32'd0);
      check("arst_flush", 32'(flush), 32'd0);
      check("arst_redirect_pc", redirect_pc, 32'h0);
      check("arst_mis_cnt", 32'(mispredict_cnt), 32'd0);
      check("arst_branch_cnt", 32'(branch_cnt), 32'd0);
      look(32'h180, 1'b0, 32'h184, "arst_lookup");
      @(negedge clk) reset = 1'b1;
      step();
      check("post_rst_redirect", 32'(redirect_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
